// File: rtl/regfile_rd2w1_if.sv
// Bus bundle for the two-read / one-write register file: write port,
// two read ports and the clear-engine handshake.
interface regfile_rd2w1_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    // Write port
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // Read port A
    logic              re_a;
    logic [ADDR_W-1:0] raddr_a;
    logic [DATA_W-1:0] rdata_a;
    logic              valid_a;

    // Read port B
    logic              re_b;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_b;
    logic              valid_b;

    // Clear engine
    logic              clr_req;
    logic              busy;

    // Datapath side that issues reads, writes and clear requests
    modport master (
        output we, waddr, wdata,
        output re_a, raddr_a,
        output re_b, raddr_b,
        output clr_req,
        input  rdata_a, valid_a,
        input  rdata_b, valid_b,
        input  busy
    );

    // Register file side
    modport slave (
        input  we, waddr, wdata,
        input  re_a, raddr_a,
        input  re_b, raddr_b,
        input  clr_req,
        output rdata_a, valid_a,
        output rdata_b, valid_b,
        output busy
    );
endinterface

// File: rtl/regfile_rd2w1.sv
// TinyMIPS register file: NREG x DATA_W, one write port, two registered
// read ports with write-first bypass, register 0 hard-wired to zero, and a
// sequential clear engine that sweeps registers 1..NREG-1, one per cycle.
module regfile_rd2w1 #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    regfile_rd2w1_if.slave bus
);

    localparam logic [0:0]        ST_IDLE    = 1'b0;
    localparam logic [0:0]        ST_CLEAR   = 1'b1;
    localparam logic [ADDR_W-1:0] PTR_FIRST  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST   = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W:0]   NREG_WIDE  = (ADDR_W + 1)'(NREG);

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic              valid_a_q, valid_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              valid_b_q, valid_b_d;

    logic              clearing;
    logic              wr_accept;

    // Register 0 and out-of-range addresses are never stored or read back.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return (addr != '0) && ({1'b0, addr} < NREG_WIDE);
    endfunction

    assign clearing  = (state_q == ST_CLEAR);
    assign wr_accept = bus.we && !clearing && addr_ok(bus.waddr);

    // Next storage contents and clear-engine state: the write and the sweep
    // are mutually exclusive because writes are dropped while clearing.
    always_comb begin
        // NOTE: every variable gets a default before any branch so this block
        // stays purely combinational and cannot infer a latch.
        mem_d   = mem_q;
        state_d = state_q;
        ptr_d   = ptr_q;

        if (wr_accept) begin
            mem_d[bus.waddr] = bus.wdata;
        end

        if (clearing) begin
            mem_d[ptr_q] = '0;
            if (ptr_q == PTR_LAST) begin
                state_d = ST_IDLE;
                ptr_d   = PTR_FIRST;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end else if (bus.clr_req) begin
            state_d = ST_CLEAR;
        end
    end

    // Read ports sample the post-edge contents, which gives write-first and
    // clear bypass for free; data holds when no request is made.
    always_comb begin
        rdata_a_d = rdata_a_q;
        valid_a_d = bus.re_a;
        rdata_b_d = rdata_b_q;
        valid_b_d = bus.re_b;

        if (bus.re_a) begin
            rdata_a_d = addr_ok(bus.raddr_a) ? mem_d[bus.raddr_a] : '0;
        end
        if (bus.re_b) begin
            rdata_b_d = addr_ok(bus.raddr_b) ? mem_d[bus.raddr_b] : '0;
        end
    end

    // Storage array; reset zeroes every register so a reset also aborts and
    // completes any clear in progress.
    always_ff @(posedge clk) begin
        // NOTE: the array is reset on purpose: architecturally every register
        // must read zero after reset, so it cannot be left as plain RAM.
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Clear-engine state and sweep pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_FIRST;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Registered read data and one-cycle valid strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a_q <= '0;
            valid_a_q <= 1'b0;
            rdata_b_q <= '0;
            valid_b_q <= 1'b0;
        end else begin
            rdata_a_q <= rdata_a_d;
            valid_a_q <= valid_a_d;
            rdata_b_q <= rdata_b_d;
            valid_b_q <= valid_b_d;
        end
    end

    assign bus.rdata_a = rdata_a_q;
    assign bus.valid_a = valid_a_q;
    assign bus.rdata_b = rdata_b_q;
    assign bus.valid_b = valid_b_q;
    assign bus.busy    = clearing;

endmodule

// File: tb/tb_regfile_rd2w1.sv
// Self-checking bench for regfile_rd2w1: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_regfile_rd2w1;

    localparam int DATA_W = 8;
    localparam int NREG   = 8;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_rd2w1_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    regfile_rd2w1 #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: architectural register contents plus the sweep.
    logic [DATA_W-1:0] m_mem [NREG];
    bit                m_clearing;
    int                m_sweep;
    logic [DATA_W-1:0] e_rd_a, e_rd_b;
    bit                e_va, e_vb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        bus_if.we      = 1'b0;
        bus_if.waddr   = '0;
        bus_if.wdata   = '0;
        bus_if.re_a    = 1'b0;
        bus_if.raddr_a = '0;
        bus_if.re_b    = 1'b0;
        bus_if.raddr_b = '0;
        bus_if.clr_req = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] img [NREG]);
        if (addr == 0 || int'(addr) >= NREG) return '0;
        return img[addr];
    endfunction

    // One clock: update the model from the inputs applied before the edge,
    // then compare every output shortly after the edge.
    task automatic step();
        logic [DATA_W-1:0] nm [NREG];
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_mem[i] = '0;
            e_rd_a = '0; e_rd_b = '0; e_va = 0; e_vb = 0;
            m_clearing = 0; m_sweep = 1;
        end else begin
            nm = m_mem;
            if (bus_if.we && !m_clearing && bus_if.waddr != 0 && int'(bus_if.waddr) < NREG)
                nm[bus_if.waddr] = bus_if.wdata;
            if (m_clearing) nm[m_sweep] = '0;
            e_va = bus_if.re_a;
            e_vb = bus_if.re_b;
            if (bus_if.re_a) e_rd_a = model_read(bus_if.raddr_a, nm);
            if (bus_if.re_b) e_rd_b = model_read(bus_if.raddr_b, nm);
            if (m_clearing) begin
                if (m_sweep == NREG - 1) begin
                    m_clearing = 0;
                    m_sweep = 1;
                end else begin
                    m_sweep++;
                end
            end else if (bus_if.clr_req) begin
                m_clearing = 1;
            end
            m_mem = nm;
        end
        #1;
        check("rdata_a", 32'(bus_if.rdata_a), 32'(e_rd_a));
        check("valid_a", 32'(bus_if.valid_a), 32'(e_va));
        check("rdata_b", 32'(bus_if.rdata_b), 32'(e_rd_b));
        check("valid_b", 32'(bus_if.valid_b), 32'(e_vb));
        check("busy",    32'(bus_if.busy),    32'(m_clearing));
    endtask

    task automatic write(input int addr, input logic [DATA_W-1:0] data);
        idle();
        bus_if.we    = 1'b1;
        bus_if.waddr = ADDR_W'(addr);
        bus_if.wdata = data;
        step();
        idle();
    endtask

    task automatic read_a(input int addr);
        idle();
        bus_if.re_a    = 1'b1;
        bus_if.raddr_a = ADDR_W'(addr);
        step();
        idle();
    endtask

    task automatic load_all();
        for (int i = 1; i < NREG; i++) write(i, DATA_W'(8'h11 * i));
    endtask

    initial begin
        int busy_len;
        idle();

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("reset_busy", 32'(bus_if.busy), 32'd0);
        check("reset_rdata_a", 32'(bus_if.rdata_a), 32'd0);
        rst = 1'b0;

        // Read every register on both ports back to back
        for (int i = 0; i < NREG; i++) begin
            idle();
            bus_if.re_a = 1'b1; bus_if.raddr_a = ADDR_W'(i);
            bus_if.re_b = 1'b1; bus_if.raddr_b = ADDR_W'(NREG - 1 - i);
            step();
            check("post_reset_a", 32'(bus_if.rdata_a), 32'd0);
            check("post_reset_valid_b", 32'(bus_if.valid_b), 32'd1);
        end
        idle();
        step();
        check("valid_a_drops", 32'(bus_if.valid_a), 32'd0);

        // Plain write and read-back; register 0 stays zero
        write(3, 8'hA5);
        read_a(3);
        check("r3_readback", 32'(bus_if.rdata_a), 32'hA5);
        write(0, 8'hFF);
        read_a(0);
        check("r0_zero", 32'(bus_if.rdata_a), 32'h00);

        // Write-first bypass on both ports
        idle();
        bus_if.we = 1'b1; bus_if.waddr = 3'd5; bus_if.wdata = 8'h3C;
        bus_if.re_a = 1'b1; bus_if.raddr_a = 3'd5;
        bus_if.re_b = 1'b1; bus_if.raddr_b = 3'd5;
        step();
        check("bypass_a", 32'(bus_if.rdata_a), 32'h3C);
        check("bypass_b", 32'(bus_if.rdata_b), 32'h3C);
        idle();

        // Clear sweep with a mid-sweep read, dropped write and repeated request
        load_all();
        bus_if.clr_req = 1'b1;
        step();
        idle();
        busy_len = 0;
        for (int c = 1; c <= 20; c++) begin
            if (!bus_if.busy) break;
            busy_len++;
            idle();
            if (c == 2) begin bus_if.re_a = 1'b1; bus_if.raddr_a = 3'd6; end
            if (c == 3) begin bus_if.we = 1'b1; bus_if.waddr = 3'd2; bus_if.wdata = 8'hEE; end
            if (c == 4) bus_if.clr_req = 1'b1;
            step();
            if (c == 2) check("read_r6_during_clear", 32'(bus_if.rdata_a), 32'h66);
        end
        idle();
        check("busy_len", 32'(busy_len), 32'(NREG - 1));
        for (int i = 0; i < NREG; i++) begin
            read_a(i);
            check("after_clear", 32'(bus_if.rdata_a), 32'h00);
        end

        // Reset during the 4th busy cycle aborts the clear
        load_all();
        bus_if.clr_req = 1'b1;
        step();
        idle();
        for (int c = 1; c <= 20; c++) begin
            if (!bus_if.busy) break;
            if (c == 4) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                break;
            end
            step();
        end
        check("busy_after_rst", 32'(bus_if.busy), 32'd0);
        for (int i = 0; i < NREG; i++) begin
            read_a(i);
            check("after_rst", 32'(bus_if.rdata_a), 32'h00);
        end
        write(4, 8'h5A);
        read_a(4);
        check("r4_after_rst", 32'(bus_if.rdata_a), 32'h5A);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus_if.we      = ($urandom_range(0, 2) != 0);
            bus_if.waddr   = ADDR_W'($urandom);
            bus_if.wdata   = DATA_W'($urandom);
            bus_if.re_a    = ($urandom_range(0, 3) != 0);
            bus_if.raddr_a = ADDR_W'($urandom);
            bus_if.re_b    = ($urandom_range(0, 3) != 0);
            bus_if.raddr_b = ($urandom_range(0, 3) == 0) ? bus_if.waddr : ADDR_W'($urandom);
            bus_if.clr_req = ($urandom_range(0, 23) == 0);
            rst            = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
